// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt entry sequencer: latches the winning event, then runs flush, drain, vector and in-ISR.
// Optional macro EXC_FAULT_ADDR_EN builds the fault_addr capture register; otherwise fault_addr is tied low.
//
//   state  | meaning
//   IDLE   | no event in service; dc exceptions and int_req are sampled here only
//   FLUSH  | one-cycle pipeline invalidate; isr rises here
//   DRAIN  | wait for pipe_empty, bounded by DRAIN_MAX cycles
//   VECTOR | redirect request held to fetch until redirect_ack
//   INISR  | handler running; iret returns to IDLE
module exc_seq_ctrl #(
  parameter logic [7:0] VEC_GP    = 8'd13,
  parameter logic [7:0] VEC_PF    = 8'd14,
  parameter logic [3:0] DRAIN_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dc_exp,
  input  logic        dc_prot_exp,
  input  logic        dc_page_fault,
  input  logic        dc_wr_exp,
  input  logic [31:0] exc_eip,
  input  logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_wr_addr,
  input  logic        int_req,
  input  logic [7:0]  int_vec,
  input  logic        pipe_empty,
  input  logic        redirect_ack,
  input  logic        iret,
  output logic        isr,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [7:0]  redirect_vec,
  output logic [31:0] saved_eip,
  output logic [31:0] fault_addr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_VECTOR = 3'd3,
    S_INISR  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] drain_cnt;
  logic       dc_take;

  // Any dc exception that is not a protection fault is serviced as a page fault,
  // so dc_page_fault itself never steers the vector.
  assign dc_take = (state == S_IDLE) && dc_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      drain_cnt      <= 4'd0;
      isr            <= 1'b0;
      pipe_flush     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_vec   <= 8'd0;
      saved_eip      <= 32'd0;
    end else begin
      pipe_flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dc_exp) begin
            state        <= S_FLUSH;
            pipe_flush   <= 1'b1;
            isr          <= 1'b1;
            redirect_vec <= dc_prot_exp ? VEC_GP : VEC_PF;
            saved_eip    <= exc_eip;
          end else if (int_req) begin
            state        <= S_FLUSH;
            pipe_flush   <= 1'b1;
            isr          <= 1'b1;
            redirect_vec <= int_vec;
          end
        end
        S_FLUSH: begin
          state     <= S_DRAIN;
          drain_cnt <= 4'd1;
        end
        // drain_cnt counts DRAIN cycles including the current one, so the
        // forced advance happens after exactly DRAIN_MAX cycles here.
        S_DRAIN: begin
          if (pipe_empty || (drain_cnt == DRAIN_MAX)) begin
            state          <= S_VECTOR;
            redirect_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        S_VECTOR: begin
          if (redirect_ack) begin
            state          <= S_INISR;
            redirect_valid <= 1'b0;
          end
        end
        S_INISR: begin
          if (iret) begin
            state <= S_IDLE;
            isr   <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          isr            <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_FAULT_ADDR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_addr <= 32'd0;
    end else if (dc_take) begin
      fault_addr <= dc_wr_exp ? mem_wr_addr : mem_rd_addr;
    end
  end

  logic unused_pf;
  assign unused_pf = dc_page_fault;
`else
  assign fault_addr = 32'd0;

  logic unused_fa;
  assign unused_fa = ^{dc_take, dc_page_fault, dc_wr_exp, mem_rd_addr, mem_wr_addr};
`endif

`ifndef SYNTHESIS
  a_flush_one_cycle : assert property (@(posedge clk) disable iff (rst)
    pipe_flush |=> !pipe_flush);
  a_vec_stable : assert property (@(posedge clk) disable iff (rst)
    (redirect_valid && !redirect_ack) |=> (redirect_valid && $stable(redirect_vec)));
  a_valid_needs_isr : assert property (@(posedge clk) disable iff (rst)
    redirect_valid |-> isr);
`endif

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed bench for exc_seq_ctrl: stimulus pushes expected redirects into a scoreboard,
// a monitor pops them at each redirect handshake; timing and reset checks are inline.
module tb_exc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dc_exp, dc_prot_exp, dc_page_fault, dc_wr_exp;
  logic [31:0] exc_eip, mem_rd_addr, mem_wr_addr;
  logic        int_req;
  logic [7:0]  int_vec;
  logic        pipe_empty, redirect_ack, iret;
  logic        isr, pipe_flush, redirect_valid;
  logic [7:0]  redirect_vec;
  logic [31:0] saved_eip, fault_addr;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0]  vec;
    logic [31:0] eip;
    logic [31:0] fa;
  } exp_t;
  exp_t sbq[$];

  exc_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .dc_exp(dc_exp), .dc_prot_exp(dc_prot_exp), .dc_page_fault(dc_page_fault),
    .dc_wr_exp(dc_wr_exp), .exc_eip(exc_eip), .mem_rd_addr(mem_rd_addr),
    .mem_wr_addr(mem_wr_addr), .int_req(int_req), .int_vec(int_vec),
    .pipe_empty(pipe_empty), .redirect_ack(redirect_ack), .iret(iret),
    .isr(isr), .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
    .redirect_vec(redirect_vec), .saved_eip(saved_eip), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_fa(input logic [31:0] a);
`ifdef EXC_FAULT_ADDR_EN
    return a;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [7:0] v, input logic [31:0] e, input logic [31:0] f);
    exp_t x;
    x.vec = v;
    x.eip = e;
    x.fa  = f;
    sbq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dc();
    dc_exp = 1'b0; dc_prot_exp = 1'b0; dc_page_fault = 1'b0; dc_wr_exp = 1'b0;
  endtask

  // Steps until redirect_valid is seen; returns the number of steps taken.
  task automatic wait_redirect(input int budget, output int cycles);
    cycles = 0;
    while (!redirect_valid && cycles < budget) begin
      step();
      cycles++;
    end
    chk("redirect_seen", {31'd0, redirect_valid}, 32'd1);
  endtask

  // Called in the VECTOR cycle with redirect_ack=1: enter INISR, retire iret, back to IDLE.
  task automatic finish_isr();
    step();
    chk("inisr_valid_low", {31'd0, redirect_valid}, 32'd0);
    chk("inisr_isr", {31'd0, isr}, 32'd1);
    iret = 1'b1;
    step();
    iret = 1'b0;
    chk("iret_isr_low", {31'd0, isr}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && redirect_valid && redirect_ack) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_redirect", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_vec", {24'd0, redirect_vec}, {24'd0, e.vec});
        chk("sb_saved_eip", saved_eip, e.eip);
        chk("sb_fault_addr", fault_addr, e.fa);
        chk("sb_isr", {31'd0, isr}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    clear_dc();
    exc_eip = 32'd0; mem_rd_addr = 32'd0; mem_wr_addr = 32'd0;
    int_req = 1'b0; int_vec = 8'd0;
    pipe_empty = 1'b1; redirect_ack = 1'b1; iret = 1'b0;
    step(); step();
    chk("rst_isr", {31'd0, isr}, 32'd0);
    chk("rst_flush", {31'd0, pipe_flush}, 32'd0);
    chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_vec", {24'd0, redirect_vec}, 32'd0);
    chk("rst_eip", saved_eip, 32'd0);
    chk("rst_fa", fault_addr, 32'd0);
    rst = 1'b0;
    step();

    // 1: page fault, ack in the same cycle as valid
    dc_exp = 1'b1; dc_page_fault = 1'b1; exc_eip = 32'h1000; mem_rd_addr = 32'h1234;
    push_exp(8'd14, 32'h1000, exp_fa(32'h1234));
    step();
    clear_dc();
    chk("t1_flush_n1", {31'd0, pipe_flush}, 32'd1);
    chk("t1_isr_n1", {31'd0, isr}, 32'd1);
    chk("t1_valid_n1", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("t1_flush_n2", {31'd0, pipe_flush}, 32'd0);
    chk("t1_valid_n2", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("t1_valid_n3", {31'd0, redirect_valid}, 32'd1);
    chk("t1_vec_n3", {24'd0, redirect_vec}, 32'd14);

    // 5: dc_exp during INISR is ignored
    step();
    chk("t5_inisr_isr", {31'd0, isr}, 32'd1);
    dc_exp = 1'b1; dc_prot_exp = 1'b1;
    step();
    clear_dc();
    chk("t5_no_flush", {31'd0, pipe_flush}, 32'd0);
    chk("t5_isr_held", {31'd0, isr}, 32'd1);
    chk("t5_vec_held", {24'd0, redirect_vec}, 32'd14);
    iret = 1'b1;
    step();
    iret = 1'b0;
    chk("t5_isr_low", {31'd0, isr}, 32'd0);
    step();
    chk("t5_idle_no_flush", {31'd0, pipe_flush}, 32'd0);

    // 2: protection beats page fault; write-path fault address
    dc_exp = 1'b1; dc_prot_exp = 1'b1; dc_page_fault = 1'b1; dc_wr_exp = 1'b1;
    exc_eip = 32'h2000; mem_wr_addr = 32'hDEAD0; mem_rd_addr = 32'h5555;
    push_exp(8'd13, 32'h2000, exp_fa(32'hDEAD0));
    step();
    clear_dc();
    wait_redirect(10, cyc);
    chk("t2_latency", cyc, 32'd2);
    finish_isr();

    // 3: exception and interrupt together; interrupt taken after iret
    dc_exp = 1'b1; dc_page_fault = 1'b1; exc_eip = 32'h3000; mem_rd_addr = 32'h7000;
    int_req = 1'b1; int_vec = 8'h20;
    push_exp(8'd14, 32'h3000, exp_fa(32'h7000));
    push_exp(8'h20, 32'h3000, exp_fa(32'h7000));
    step();
    clear_dc();
    wait_redirect(10, cyc);
    finish_isr();
    step();
    chk("t3_int_flush", {31'd0, pipe_flush}, 32'd1);
    int_req = 1'b0;
    wait_redirect(10, cyc);
    chk("t3_int_vec", {24'd0, redirect_vec}, 32'h20);
    finish_isr();

    // 4: drain timeout and ack backpressure
    pipe_empty = 1'b0; redirect_ack = 1'b0;
    dc_exp = 1'b1; dc_prot_exp = 1'b1; exc_eip = 32'h4000; mem_rd_addr = 32'h8000;
    push_exp(8'd13, 32'h4000, exp_fa(32'h8000));
    step();
    clear_dc();
    wait_redirect(40, cyc);
    chk("t4_drain_latency", cyc, 32'd16);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_valid_hold", {31'd0, redirect_valid}, 32'd1);
      chk("t4_vec_hold", {24'd0, redirect_vec}, 32'd13);
    end
    redirect_ack = 1'b1; pipe_empty = 1'b1;
    finish_isr();

    // 6: async reset while in VECTOR, then clean re-entry
    redirect_ack = 1'b0;
    dc_exp = 1'b1; dc_page_fault = 1'b1; exc_eip = 32'h5000; mem_rd_addr = 32'h9000;
    step();
    clear_dc();
    wait_redirect(10, cyc);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, redirect_valid}, 32'd0);
    chk("t6_async_isr", {31'd0, isr}, 32'd0);
    chk("t6_async_vec", {24'd0, redirect_vec}, 32'd0);
    chk("t6_async_eip", saved_eip, 32'd0);
    chk("t6_async_fa", fault_addr, 32'd0);
    rst = 1'b0;
    redirect_ack = 1'b1;
    step();
    chk("t6_idle_after_rst", {31'd0, pipe_flush}, 32'd0);
    dc_exp = 1'b1; dc_prot_exp = 1'b1; exc_eip = 32'h6000; mem_rd_addr = 32'hA000;
    push_exp(8'd13, 32'h6000, exp_fa(32'hA000));
    step();
    clear_dc();
    chk("t6_reentry_flush", {31'd0, pipe_flush}, 32'd1);
    wait_redirect(10, cyc);
    finish_isr();

    step(); step();
    chk("sb_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
